// File: rtl/imem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter_if
//   Bundles the fetch, LSU and memory-side signals of imem_port_arbiter.
//   Signal names keep the arbiter-relative _i/_o suffixes of the original
//   port list, so "_i" is always driven into the arbiter.
//
//   Fetch side : flush_i, i_en_i, i_addr_i -> arbiter; i_rdata_o, i_rvalid_o <-
//   LSU side   : d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i -> arbiter;
//                d_gnt_o, d_rdata_o, d_rvalid_o <-
//   Memory side: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o <-
//                mem_gnt_i, mem_rvalid_i, mem_rdata_i -> arbiter
//
//   Modports: slave  = the arbiter's view
//             master = the surrounding fetch/LSU/memory environment's view
// ---------------------------------------------------------------------------
interface imem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  flush_i;
   logic                  i_en_i;
   logic [ADDR_W-1:0]     i_addr_i;
   logic [DATA_W-1:0]     i_rdata_o;
   logic                  i_rvalid_o;

   logic                  d_req_i;
   logic                  d_we_i;
   logic [ADDR_W-1:0]     d_addr_i;
   logic [DATA_W-1:0]     d_wdata_i;
   logic [DATA_W/8-1:0]   d_wstrb_i;
   logic                  d_gnt_o;
   logic [DATA_W-1:0]     d_rdata_o;
   logic                  d_rvalid_o;

   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [ADDR_W-1:0]     mem_addr_o;
   logic [DATA_W-1:0]     mem_wdata_o;
   logic [DATA_W/8-1:0]   mem_wstrb_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [DATA_W-1:0]     mem_rdata_i;

   modport slave (
      input  flush_i, i_en_i, i_addr_i,
      output i_rdata_o, i_rvalid_o,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
      output d_gnt_o, d_rdata_o, d_rvalid_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport master (
      output flush_i, i_en_i, i_addr_i,
      input  i_rdata_o, i_rvalid_o,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
      input  d_gnt_o, d_rdata_o, d_rvalid_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
//   Shares one memory port between the fetch stage (single-cycle i_en_i
//   pulse, later i_rvalid_o) and the LSU (d_req_i/d_gnt_o request,
//   d_rvalid_o response). One memory transaction is outstanding at a time;
//   contention is resolved round-robin. A fetch flush drops the buffered
//   fetch and suppresses the response of an instruction transaction already
//   on the port, which still runs to completion on the memory side.
//
//   Ports:
//     clk   - clock
//     rst_n - synchronous, active-low reset
//     bus   - imem_port_arbiter_if.slave carrying the fetch, LSU and memory
//             handshakes (see the interface header for the signal list)
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   imem_port_arbiter_if.slave bus
);
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   typedef enum logic       {OWN_I, OWN_D}    owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q;
   logic                rr_q;        // 1: D side wins the next contention
   logic                squash_q;
   logic                i_pend_q;
   logic [ADDR_W-1:0]   i_addr_q;

   logic                mem_req_q, mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [STRB_W-1:0]   mem_wstrb_q;

   logic                i_rvalid_q, d_rvalid_q;
   logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

   logic                i_inflight, i_capture;
   logic                cand_i, cand_d, grant_i, grant_d, rsp_i, rsp_d;
   logic [ADDR_W-1:0]   i_issue_addr;

   // An unsquashed instruction transaction still owes the fetch stage data,
   // so a new fetch pulse during it is a protocol violation and is ignored.
   assign i_inflight   = (state_q != IDLE) && (owner_q == OWN_I) && !squash_q;
   assign i_capture    = bus.i_en_i && !bus.flush_i && !i_pend_q && !i_inflight;
   // A fetch arriving in IDLE competes in the same cycle; it only lands in
   // the buffer if it loses arbitration.
   assign i_issue_addr = i_pend_q ? i_addr_q : bus.i_addr_i;

   always_comb begin
      state_d = state_q;
      cand_i  = 1'b0;
      cand_d  = 1'b0;
      grant_i = 1'b0;
      grant_d = 1'b0;
      rsp_i   = 1'b0;
      rsp_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cand_i = (i_pend_q || i_capture) && !bus.flush_i;
            cand_d = bus.d_req_i;
            if (cand_i && cand_d) begin
               grant_d = rr_q;
               grant_i = !rr_q;
            end else begin
               grant_i = cand_i;
               grant_d = cand_d;
            end
            if (grant_i || grant_d) state_d = REQ;
         end
         REQ: begin
            if (bus.mem_gnt_i) state_d = WAIT;
         end
         WAIT: begin
            if (bus.mem_rvalid_i) begin
               state_d = IDLE;
               rsp_d   = (owner_q == OWN_D);
               rsp_i   = (owner_q == OWN_I) && !squash_q && !bus.flush_i;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_I;
         rr_q        <= 1'b0;
         squash_q    <= 1'b0;
         i_pend_q    <= 1'b0;
         i_addr_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         i_rvalid_q <= rsp_i;
         d_rvalid_q <= rsp_d;
         if (rsp_i) i_rdata_q <= bus.mem_rdata_i;
         if (rsp_d) d_rdata_q <= bus.mem_rdata_i;

         // Priority moves to the loser only when both sides contended.
         if (cand_i && cand_d) rr_q <= grant_i;

         if (bus.flush_i || grant_i) begin
            i_pend_q <= 1'b0;
         end else if (i_capture) begin
            i_pend_q <= 1'b1;
            i_addr_q <= bus.i_addr_i;
         end

         if (state_q == WAIT && bus.mem_rvalid_i)
            squash_q <= 1'b0;
         else if (bus.flush_i && owner_q == OWN_I && state_q != IDLE)
            squash_q <= 1'b1;

         if (grant_i) begin
            owner_q     <= OWN_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_issue_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '1;
         end else if (grant_d) begin
            owner_q     <= OWN_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we_i;
            mem_addr_q  <= bus.d_addr_i;
            mem_wdata_q <= bus.d_wdata_i;
            mem_wstrb_q <= bus.d_wstrb_i;
         end else if (state_q == REQ && bus.mem_gnt_i) begin
            mem_req_q   <= 1'b0;
         end
      end
   end

   assign bus.d_gnt_o     = grant_d && rst_n;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.mem_wstrb_o = mem_wstrb_q;
   assign bus.i_rvalid_o  = i_rvalid_q;
   assign bus.i_rdata_o   = i_rdata_q;
   assign bus.d_rvalid_o  = d_rvalid_q;
   assign bus.d_rdata_o   = d_rdata_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter
//   Directed scenarios for single fetch, contention, stores, flushes and
//   reset, followed by a randomized phase with a randomly timed memory
//   responder. A transaction-level reference model tracks whether the port
//   is busy, who owns it, whether memory has accepted it and whether the
//   fetch side was flushed, and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   imem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        busy;        // a transaction owns the memory port
      logic        owner_d;
      logic        accepted;    // memory has taken the request
      logic        squashed;    // fetch response must not be delivered
      logic        pref_d;      // D side wins the next tie
      logic        have_fetch;
      logic [31:0] fetch_addr;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        i_rv;
      logic        d_rv;
      logic [31:0] i_rdata;
      logic [31:0] d_rdata;
   } model_t;

   model_t ms = '0;

   function automatic logic fetch_wants_port(model_t s);
      return !s.busy && !bus.flush_i && (s.have_fetch || bus.i_en_i);
   endfunction

   function automatic logic exp_gnt(model_t s);
      return rst_n && !s.busy && bus.d_req_i && (s.pref_d || !fetch_wants_port(s));
   endfunction

   function automatic model_t model_step(model_t s);
      model_t n = s;
      logic   want_i, take_i, take_d, contend, new_fetch;
      if (!rst_n) return '0;
      want_i    = fetch_wants_port(s);
      take_d    = exp_gnt(s);
      take_i    = want_i && !take_d;
      contend   = want_i && bus.d_req_i;
      new_fetch = bus.i_en_i && !bus.flush_i && !s.have_fetch &&
                  !(s.busy && !s.owner_d && !s.squashed);
      n.i_rv = 1'b0;
      n.d_rv = 1'b0;
      if (s.busy && !s.owner_d && bus.flush_i) n.squashed = 1'b1;
      if (s.busy) begin
         if (!s.accepted) begin
            if (bus.mem_gnt_i) begin
               n.accepted = 1'b1;
               n.req      = 1'b0;
            end
         end else if (bus.mem_rvalid_i) begin
            n.busy = 1'b0;
            if (s.owner_d) begin
               n.d_rv    = 1'b1;
               n.d_rdata = bus.mem_rdata_i;
            end else if (!n.squashed) begin
               n.i_rv    = 1'b1;
               n.i_rdata = bus.mem_rdata_i;
            end
         end
      end else if (take_i || take_d) begin
         if (contend) n.pref_d = !s.pref_d;
         n.busy     = 1'b1;
         n.accepted = 1'b0;
         n.squashed = 1'b0;
         n.owner_d  = take_d;
         n.req      = 1'b1;
         if (take_i) begin
            n.we    = 1'b0;
            n.addr  = s.have_fetch ? s.fetch_addr : bus.i_addr_i;
            n.wdata = '0;
            n.strb  = 4'hF;
         end else begin
            n.we    = bus.d_we_i;
            n.addr  = bus.d_addr_i;
            n.wdata = bus.d_wdata_i;
            n.strb  = bus.d_wstrb_i;
         end
      end
      if (bus.flush_i || take_i) begin
         n.have_fetch = 1'b0;
      end else if (new_fetch) begin
         n.have_fetch = 1'b1;
         n.fetch_addr = bus.i_addr_i;
      end
      return n;
   endfunction

   always @(posedge clk) ms <= model_step(ms);

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      #2;
      chk1("mem_req", bus.mem_req_o, ms.req);
      if (ms.req) begin
         chk1 ("mem_we",    bus.mem_we_o,    ms.we);
         chk32("mem_addr",  bus.mem_addr_o,  ms.addr);
         chk32("mem_wdata", bus.mem_wdata_o, ms.wdata);
         chk32("mem_wstrb", 32'(bus.mem_wstrb_o), 32'(ms.strb));
      end
      chk1 ("i_rvalid", bus.i_rvalid_o, ms.i_rv);
      chk32("i_rdata",  bus.i_rdata_o,  ms.i_rdata);
      chk1 ("d_rvalid", bus.d_rvalid_o, ms.d_rv);
      chk32("d_rdata",  bus.d_rdata_o,  ms.d_rdata);
      chk1 ("d_gnt",    bus.d_gnt_o,    exp_gnt(ms));
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge clk);
      bus.i_en_i       = 1'b0;
      bus.flush_i      = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
   endtask

   // Grant after gd cycles, respond rd cycles after the grant; returns in
   // the cycle where the response pulse is visible.
   task automatic serve(input int gd, input int rd, input logic [31:0] data);
      repeat (gd) cyc();
      bus.mem_gnt_i = 1'b1;
      cyc();
      repeat (rd) cyc();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = data;
      cyc();
   endtask

   task automatic d_drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st);
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = we;
      bus.d_addr_i  = a;
      bus.d_wdata_i = wd;
      bus.d_wstrb_i = st;
   endtask

   logic owed, prev_gnt, prev_req, prev_rv, holding, got_gnt;

   initial begin
      rst_n = 1'b0;
      bus.flush_i = 0; bus.i_en_i = 0; bus.i_addr_i = '0;
      bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_wstrb_i = '0;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
      repeat (3) cyc();
      rst_n = 1'b1;
      #1;
      chk1 ("rst_mem_req",  bus.mem_req_o,  1'b0);
      chk32("rst_mem_addr", bus.mem_addr_o, 32'h0);
      chk1 ("rst_i_rvalid", bus.i_rvalid_o, 1'b0);
      chk1 ("rst_d_rvalid", bus.d_rvalid_o, 1'b0);
      chk1 ("rst_d_gnt",    bus.d_gnt_o,    1'b0);

      // single fetch
      cyc(); bus.i_en_i = 1; bus.i_addr_i = 32'h100;
      cyc(); #1;
      chk1 ("sf_req_t1",  bus.mem_req_o,  1'b1);
      chk32("sf_addr",    bus.mem_addr_o, 32'h100);
      chk32("sf_strb",    32'(bus.mem_wstrb_o), 32'hF);
      chk1 ("sf_we",      bus.mem_we_o,   1'b0);
      cyc(); bus.mem_gnt_i = 1; #1;
      chk1 ("sf_req_t2",  bus.mem_req_o,  1'b1);
      cyc(); #1;
      chk1 ("sf_req_t3",  bus.mem_req_o,  1'b0);
      cyc(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h00500093;
      cyc(); #1;
      chk1 ("sf_i_rvalid", bus.i_rvalid_o, 1'b1);
      chk32("sf_i_rdata",  bus.i_rdata_o,  32'h00500093);
      chk1 ("sf_d_rvalid", bus.d_rvalid_o, 1'b0);
      cyc(); #1;
      chk1 ("sf_i_pulse_end", bus.i_rvalid_o, 1'b0);

      // simultaneous requests: I first, then D first on the repeat
      cyc(); bus.i_en_i = 1; bus.i_addr_i = 32'h0; d_drive(0, 32'h2000, 32'h0, 4'hF); #1;
      chk1 ("sim_no_gnt", bus.d_gnt_o, 1'b0);
      cyc(); #1;
      chk32("sim_i_addr", bus.mem_addr_o, 32'h0);
      serve(0, 0, 32'h11111111); #1;
      chk1 ("sim_i_rv",   bus.i_rvalid_o, 1'b1);
      chk1 ("sim_d_gnt",  bus.d_gnt_o,    1'b1);
      cyc(); bus.d_req_i = 0; #1;
      chk32("sim_d_addr", bus.mem_addr_o, 32'h2000);
      serve(1, 1, 32'h22222222); #1;
      chk1 ("sim_d_rv",    bus.d_rvalid_o, 1'b1);
      chk32("sim_d_rdata", bus.d_rdata_o,  32'h22222222);
      cyc(); bus.i_en_i = 1; bus.i_addr_i = 32'h8; d_drive(0, 32'h2008, 32'h0, 4'hF); #1;
      chk1 ("rr_d_first", bus.d_gnt_o, 1'b1);
      cyc(); bus.d_req_i = 0; #1;
      chk32("rr_d_addr", bus.mem_addr_o, 32'h2008);
      serve(0, 0, 32'h33333333);
      cyc(); #1;
      chk1 ("rr_i_req",  bus.mem_req_o,  1'b1);
      chk32("rr_i_addr", bus.mem_addr_o, 32'h8);
      serve(0, 0, 32'h44444444); #1;
      chk32("rr_i_rdata", bus.i_rdata_o, 32'h44444444);

      // store
      cyc(); d_drive(1, 32'h2004, 32'hDEADBEEF, 4'h3); #1;
      chk1 ("st_gnt", bus.d_gnt_o, 1'b1);
      cyc(); bus.d_req_i = 0; bus.d_we_i = 0; #1;
      chk1 ("st_we",    bus.mem_we_o,    1'b1);
      chk32("st_addr",  bus.mem_addr_o,  32'h2004);
      chk32("st_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
      chk32("st_strb",  32'(bus.mem_wstrb_o), 32'h3);
      serve(0, 1, 32'h0); #1;
      chk1 ("st_d_rv", bus.d_rvalid_o, 1'b1);

      // flush in WAIT, then a new fetch
      cyc(); bus.i_en_i = 1; bus.i_addr_i = 32'h10;
      cyc(); bus.mem_gnt_i = 1;
      cyc(); bus.flush_i = 1;
      cyc(); bus.i_en_i = 1; bus.i_addr_i = 32'h40; #1;
      chk1 ("fw_no_req", bus.mem_req_o, 1'b0);
      cyc(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0BAD0010;
      cyc(); #1;
      chk1 ("fw_squashed", bus.i_rvalid_o, 1'b0);
      cyc(); #1;
      chk32("fw_new_addr", bus.mem_addr_o, 32'h40);
      serve(0, 0, 32'h600DD040); #1;
      chk1 ("fw_new_rv",    bus.i_rvalid_o, 1'b1);
      chk32("fw_new_rdata", bus.i_rdata_o,  32'h600DD040);

      // fetch pulse in a flush cycle is dropped
      cyc(); bus.i_en_i = 1; bus.flush_i = 1; bus.i_addr_i = 32'h80;
      cyc(); #1; chk1("fe_drop_1", bus.mem_req_o, 1'b0);
      cyc(); #1; chk1("fe_drop_2", bus.mem_req_o, 1'b0);

      // flush coincident with the I response
      cyc(); bus.i_en_i = 1; bus.i_addr_i = 32'h20;
      cyc(); bus.mem_gnt_i = 1;
      cyc(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h12345678; bus.flush_i = 1;
      cyc(); #1; chk1("fe_rv_flush", bus.i_rvalid_o, 1'b0);

      // reset during a D transaction, then a stray response
      cyc(); d_drive(0, 32'h3000, 32'h0, 4'hF); #1;
      chk1 ("rm_gnt", bus.d_gnt_o, 1'b1);
      cyc(); bus.d_req_i = 0; #1;
      chk1 ("rm_req", bus.mem_req_o, 1'b1);
      rst_n = 1'b0;
      cyc(); rst_n = 1'b1; #1;
      chk1 ("rm_mem_req",  bus.mem_req_o,  1'b0);
      chk32("rm_mem_addr", bus.mem_addr_o, 32'h0);
      chk1 ("rm_d_rvalid", bus.d_rvalid_o, 1'b0);
      cyc(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hFACEFACE;
      cyc(); #1; chk1("rm_stray", bus.d_rvalid_o, 1'b0);

      // randomized phase
      owed = 0; prev_gnt = 0; prev_req = 0; prev_rv = 0; holding = 0; got_gnt = 0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         if (prev_rv) owed = 1'b0;
         if (prev_gnt && prev_req) owed = 1'b1;
         if (holding && got_gnt) holding = 1'b0;
         if (!holding && $urandom_range(2) == 0) begin
            holding = 1'b1;
            d_drive(1'($urandom_range(1)), $urandom & 32'hFFFC, $urandom,
                    4'($urandom_range(15)));
         end
         bus.d_req_i = holding;
         if ($urandom_range(3) == 0) begin
            bus.i_en_i   = 1'b1;
            bus.i_addr_i = $urandom & 32'hFFFC;
         end
         if ($urandom_range(15) == 0) bus.flush_i = 1'b1;
         if (owed && $urandom_range(2) != 0) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = $urandom;
         end else if (bus.mem_req_o) begin
            bus.mem_gnt_i = 1'($urandom_range(1));
         end else begin
            bus.mem_gnt_i = ($urandom_range(9) == 0);
         end
         prev_gnt = bus.mem_gnt_i;
         prev_req = bus.mem_req_o;
         prev_rv  = bus.mem_rvalid_i;
         #1 got_gnt = bus.d_gnt_o;
      end
      bus.d_req_i = 1'b0;
      repeat (4) cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/imem_port_arbiter.md
Name:
imem_port_arbiter

Overview:
- Shares one memory port between the fetch stage's icache-style interface (single-cycle en pulse, later rvalid) and the LSU data port (req/gnt request, rvalid response).
- One transaction is outstanding at a time, with round-robin priority between the two sides.
- Fetch flush squashes the instruction-side request or response in flight.
- Sits between fetch/LSU and the instruction/data memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 strobe bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- flush_i  in  1  fetch flush; squashes instruction side
- i_en_i  in  1  fetch request pulse (one cycle)
- i_addr_i  in  ADDR_W  fetch address, valid with i_en_i
- i_rdata_o  out  DATA_W  instruction data
- i_rvalid_o  out  1  instruction response pulse
- d_req_i  in  1  data request; held until d_gnt_o
- d_we_i  in  1  write enable
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_wstrb_i  in  DATA_W/8  byte strobes
- d_gnt_o  out  1  data request accepted (pulse)
- d_rdata_o  out  DATA_W  load data
- d_rvalid_o  out  1  data response pulse (loads and stores)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_wstrb_o  out  DATA_W/8  memory strobes; all-ones for instruction reads
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response pulse (every transaction)
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- **Reset.** All outputs are 0. State is IDLE, the I-side request buffer is empty, the squash flag is clear, and rr_q=0 (I side preferred).
- **I-side capture.** When i_en_i=1 and flush_i=0, {i_addr_i} is latched into the I buffer (i_pend=1).
  - i_en_i in a flush_i cycle is dropped.
  - i_en_i while i_pend=1, or while an unsquashed I transaction is in flight, is a protocol violation and is ignored.
- **D side.** d_req_i is a level. It is eligible whenever d_req_i=1.
- **FSM IDLE.**
  - Candidates are i_pend (excluding when flush_i=1) and d_req_i.
  - If both are present, the side with rr_q priority wins; otherwise the single candidate wins. rr_q then points to the loser (0 = I preferred, 1 = D preferred).
  - I wins: load the mem_* registers from the I buffer with we=0 and strb=all-ones; clear i_pend; owner=I; go to REQ.
  - D wins: load the mem_* registers from the d_* inputs; pulse d_gnt_o that cycle; owner=D; go to REQ.
- **FSM REQ.** mem_req_o=1 with stable address, data and strobes. On mem_gnt_i=1: deassert mem_req_o next cycle and go to WAIT.
- **FSM WAIT.** On mem_rvalid_i=1, go to IDLE.
  - owner=D: next cycle d_rvalid_o=1 and d_rdata_o=mem_rdata_i.
  - owner=I with squash=0 and flush_i=0: next cycle i_rvalid_o=1 and i_rdata_o=mem_rdata_i.
  - Otherwise the response is dropped. Clear squash.
- **Response outputs.** i_rvalid_o and d_rvalid_o are single-cycle registered pulses. Rdata holds its last value between pulses.
- **Latency.** Request to mem_req_o is 1 cycle. Response is 1 cycle after mem_rvalid_i. Minimum turnaround is IDLE→REQ→WAIT→IDLE.
- **Flush.**
  - Clears i_pend.
  - If owner=I and state is REQ or WAIT, sets squash. The memory transaction still completes (request held until gnt); only the I response is suppressed.
  - A new post-flush i_en_i may be captured while the squashed transaction is in flight. It issues after the squashed transaction returns to IDLE.
  - Flush has no effect on a D transaction.
- **Memory protocol.**
  - mem_rvalid_i outside WAIT is ignored.
  - mem_rvalid_i in the same cycle as mem_gnt_i is not permitted.
  - mem_gnt_i outside REQ is ignored.
- **Reset mid-transaction.** Returns to IDLE immediately. A later stray mem_rvalid_i is ignored.

Test Plan:
- **Single fetch.** i_en_i @t0 with i_addr_i=0x100; mem gnt at t2, rvalid with rdata=0x00500093 at t4 → mem_req_o=1 at t1–t2, addr=0x100, strb=0xF; i_rvalid_o=1 at t5 with i_rdata_o=0x00500093; d_rvalid_o=0 throughout.
- **Simultaneous requests from reset.** i_en_i (addr=0x0) and d_req_i (load, addr=0x2000) both at t0 → I is served first; d_gnt_o pulses only after the I response completes. A repeat of simultaneous requests then grants D first (rr_q=1).
- **Store.** d_req_i we=1, addr=0x2004, wdata=0xDEADBEEF, strb=0x3 → d_gnt_o pulse; mem_we_o=1 with those values; d_rvalid_o pulse after mem_rvalid_i.
- **Flush in WAIT.** I transaction to 0x10 in WAIT, flush_i=1; then i_en_i with addr=0x40 → no i_rvalid_o for 0x10; the 0x40 request issues after the 0x10 rvalid, and i_rvalid_o later returns data for 0x40 only.
- **Flush edge cases.**
  - i_en_i with flush_i=1 in the same cycle → request dropped; mem_req_o stays 0.
  - flush_i coincident with mem_rvalid_i for I → i_rvalid_o stays 0.
- **Reset mid-operation.** rst_n=0 during REQ with owner=D → all outputs 0 the next cycle. A mem_rvalid_i after reset release produces no d_rvalid_o.
